store_trace_monitor: RTL and testbench
======================================

Name: store_trace_monitor

Overview:
- Synthesizable monitor that sits directly downstream of the single-cycle ARM core's data-memory write port.
- Observes MemWrite/DataAdr/WriteData/PC every cycle and captures each store into a trace FIFO, drained through a valid/ready interface.
- Runs a pass/fail checker: one expected (address, data) store against a cycle timeout.
- Gives bench and FPGA top one self-checking completion signal instead of hierarchical probing.

Parameters:
- DEPTH, 8, trace FIFO entries; power of two, 2..64.
- MAX_CYCLES, 1000, cycles after reset deassertion before timeout FAIL; >= 1.
- CNT_W, 16, width of store_count and drop_count.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- MemWrite  in  1  core store strobe, sampled at rising clk.
- DataAdr  in  32  store byte address.
- WriteData  in  32  store data.
- PC  in  32  PC of the storing instruction.
- chk_addr  in  32  expected store address; static after reset.
- chk_data  in  32  expected store data; static after reset.
- trace_valid  out  1  FIFO head valid.
- trace_ready  in  1  consumer accepts head.
- trace_pc  out  32  head PC.
- trace_addr  out  32  head address.
- trace_data  out  32  head data.
- overflow  out  1  sticky; a store was dropped.
- store_count  out  CNT_W  stores observed, saturating.
- drop_count  out  CNT_W  stores dropped, saturating.
- done  out  1  checker reached PASS or FAIL.
- pass  out  1  checker PASS.
- fail  out  1  checker FAIL.

Behaviour:
- Reset state: FIFO empty, trace_valid=0, trace_* = 0, overflow=0, counts=0, done=pass=fail=0, checker in RUN, cycle counter=0.
- Push: occurs on a rising edge with MemWrite=1.
- Entry content: {PC, DataAdr, WriteData} as sampled at that edge.
- Push latency: entry is visible at the head no earlier than the next cycle. There is no combinational bypass from inputs to trace_* outputs.
- Pop: occurs on a rising edge with trace_valid && trace_ready. trace_* are stable while trace_valid=1 and trace_ready=0.
- Full FIFO, push without pop: entry is dropped, drop_count increments, overflow sets and stays set until reset.
- Full FIFO, simultaneous push and pop: both take effect. Occupancy is unchanged and nothing is dropped.
- Empty FIFO, simultaneous push and pop: impossible, since trace_valid=0. The push lands normally.
- Pointers: read and write pointers have log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full and empty are decoded from MSB and index comparison.
- store_count: increments on every MemWrite edge, whether the store is captured or dropped. Saturates at 2^CNT_W-1, as does drop_count.
- Checker FSM has three states:
  - RUN: on a MemWrite edge with DataAdr==chk_addr and WriteData==chk_data, go to PASS.
  - RUN: on a MemWrite edge with DataAdr==chk_addr and WriteData!=chk_data, go to FAIL.
  - RUN: otherwise, when the cycle counter reaches MAX_CYCLES-1 with no match, go to FAIL.
  - Address match precedes timeout on the same edge.
  - PASS and FAIL are terminal until reset.
  - Cycle counter stops in PASS/FAIL.
- Checker outputs: registered, asserted the cycle after the deciding edge. done = pass | fail; pass and fail are mutually exclusive.
- Tracing after done: FIFO capture and the counters keep operating in PASS/FAIL.
- Reset mid-operation: asserting reset at any time immediately clears the FIFO contents, counts and checker. In-flight drains are discarded.

Test Plan:
- Reset, then one store PC=0x10, addr=0x64, data=7, with chk=(0x64,7) and trace_ready=1 -> next cycle trace_valid=1 with head (0x10,0x64,7); pass=1, done=1; store_count=1.
- Store to 0x64 with data 5 against chk=(0x64,7) -> fail=1, pass=0, done=1.
- No store to chk_addr, MAX_CYCLES=20 -> fail asserts exactly 20 cycles after reset deassertion.
- DEPTH=8, trace_ready=0, 10 consecutive stores -> 8 entries held in order; drop_count=2, overflow=1, store_count=10. Then trace_ready=1 -> 8 pops in store order, then trace_valid=0.
- FIFO full, trace_ready=1 and MemWrite=1 each cycle for 20 cycles -> no drops, occupancy stays 8, pointers wrap, order preserved.
- Reset asserted asynchronously mid-drain with 4 entries queued -> trace_valid, counts, overflow and done all 0 before the next clk edge.

Source files
------------

// File: rtl/store_trace_monitor.sv
// Store trace monitor: captures core data-memory stores into a FIFO
// and runs a single-store pass/fail checker with a cycle timeout.
module store_trace_monitor #(
    parameter int DEPTH      = 8,
    parameter int MAX_CYCLES = 1000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      DataAdr,
    input  logic [31:0]      WriteData,
    input  logic [31:0]      PC,
    input  logic [31:0]      chk_addr,
    input  logic [31:0]      chk_data,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_addr,
    output logic [31:0]      trace_data,
    output logic             overflow,
    output logic [CNT_W-1:0] store_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;
    localparam int CYC_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } traceEntry_t;

    typedef enum logic [1:0] {
        stRun  = 2'd0,
        stPass = 2'd1,
        stFail = 2'd2
    } chkState_t;

    traceEntry_t mem [DEPTH];
    traceEntry_t headEntry;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [IDX_W-1:0] wrIdx;
    logic [IDX_W-1:0] rdIdx;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             doPop;
    logic             doPush;
    logic             doDrop;

    logic [CNT_W-1:0] storeCnt;
    logic [CNT_W-1:0] dropCnt;
    logic             overflowSticky;

    chkState_t        state;
    chkState_t        stateNext;
    logic [CYC_W-1:0] cycleCnt;
    logic             addrHit;
    logic             dataHit;
    logic             timeout;

    assign wrIdx     = wrPtr[IDX_W-1:0];
    assign rdIdx     = rdPtr[IDX_W-1:0];
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PTR_W-1] != rdPtr[PTR_W-1])
                    && (wrIdx == rdIdx);

    // A full FIFO still accepts a store when the head leaves on the same edge.
    assign doPop  = !fifoEmpty && trace_ready;
    assign doPush = MemWrite && (!fifoFull || doPop);
    assign doDrop = MemWrite && fifoFull && !doPop;

    // Storage array needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrIdx] <= '{pc: PC, addr: DataAdr, data: WriteData};
        end
    end

    // Read/write pointers carry a wrap bit to tell full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
        end
    end

    // Head presentation, forced to zero when nothing is queued.
    always_comb begin
        headEntry   = mem[rdIdx];
        trace_valid = !fifoEmpty;
        trace_pc    = '0;
        trace_addr  = '0;
        trace_data  = '0;
        if (!fifoEmpty) begin
            trace_pc   = headEntry.pc;
            trace_addr = headEntry.addr;
            trace_data = headEntry.data;
        end
    end

    // Saturating store/drop counters and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            storeCnt       <= '0;
            dropCnt        <= '0;
            overflowSticky <= 1'b0;
        end else begin
            if (MemWrite && storeCnt != '1) storeCnt <= storeCnt + CNT_W'(1);
            if (doDrop && dropCnt != '1)    dropCnt  <= dropCnt + CNT_W'(1);
            if (doDrop)                     overflowSticky <= 1'b1;
        end
    end

    assign store_count = storeCnt;
    assign drop_count  = dropCnt;
    assign overflow    = overflowSticky;

    assign addrHit = MemWrite && (DataAdr == chk_addr);
    assign dataHit = (WriteData == chk_data);
    assign timeout = (cycleCnt == CYC_W'(MAX_CYCLES - 1));

    // Checker state register; the cycle counter freezes once decided.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= stRun;
            cycleCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == stRun && !timeout) cycleCnt <= cycleCnt + CYC_W'(1);
        end
    end

    // Checker next state: an address hit outranks the timeout.
    always_comb begin
        stateNext = state;
        unique case (state)
            stRun: begin
                if (addrHit)      stateNext = dataHit ? stPass : stFail;
                else if (timeout) stateNext = stFail;
            end
            default: stateNext = state;
        endcase
    end

    // Checker outputs decoded straight from the state register.
    always_comb begin
        pass = 1'b0;
        fail = 1'b0;
        unique case (1'b1)
            (state == stPass): pass = 1'b1;
            (state == stFail): fail = 1'b1;
            default: ;
        endcase
        done = pass | fail;
    end

endmodule

// File: tb/tb_store_trace_monitor.sv
// Directed bench for store_trace_monitor: checker verdicts, timeout,
// overflow/drain order, full-FIFO streaming and async reset.
module tb_store_trace_monitor;

    localparam int DEPTH = 8;
    localparam int MAXC  = 20;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite;
    logic [31:0]   DataAdr;
    logic [31:0]   WriteData;
    logic [31:0]   PC;
    logic [31:0]   chk_addr;
    logic [31:0]   chk_data;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic          overflow;
    logic [CW-1:0] store_count;
    logic [CW-1:0] drop_count;
    logic          done;
    logic          pass;
    logic          fail;

    int nChecks = 0;
    int nPass   = 0;

    store_trace_monitor #(
        .DEPTH(DEPTH),
        .MAX_CYCLES(MAXC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .PC(PC),
        .chk_addr(chk_addr),
        .chk_data(chk_data),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .trace_pc(trace_pc),
        .trace_addr(trace_addr),
        .trace_data(trace_data),
        .overflow(overflow),
        .store_count(store_count),
        .drop_count(drop_count),
        .done(done),
        .pass(pass),
        .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [31:0] a, input logic [31:0] d);
        reset       = 1'b1;
        MemWrite    = 1'b0;
        trace_ready = 1'b0;
        PC          = '0;
        DataAdr     = '0;
        WriteData   = '0;
        chk_addr    = a;
        chk_data    = d;
        tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] d);
        MemWrite  = 1'b1;
        PC        = p;
        DataAdr   = a;
        WriteData = d;
    endtask

    task automatic checkHead(input string tag, input int i);
        check({tag, ".v"},  {31'd0, trace_valid}, 32'd1);
        check({tag, ".pc"}, trace_pc,   32'h100 + 32'(4 * i));
        check({tag, ".ad"}, trace_addr, 32'h200 + 32'(4 * i));
        check({tag, ".da"}, trace_data, 32'hA0 + 32'(i));
    endtask

    initial begin
        // Reset state
        doReset(32'h64, 32'd7);
        check("rst.valid", {31'd0, trace_valid}, 32'd0);
        check("rst.pc",    trace_pc, 32'd0);
        check("rst.ovf",   {31'd0, overflow}, 32'd0);
        check("rst.cnt",   32'(store_count), 32'd0);
        check("rst.done",  {31'd0, done}, 32'd0);

        // Matching store -> PASS
        trace_ready = 1'b1;
        store(32'h10, 32'h64, 32'd7);
        tick();
        MemWrite = 1'b0;
        check("p.valid", {31'd0, trace_valid}, 32'd1);
        check("p.pc",    trace_pc,   32'h10);
        check("p.addr",  trace_addr, 32'h64);
        check("p.data",  trace_data, 32'd7);
        check("p.pass",  {31'd0, pass}, 32'd1);
        check("p.done",  {31'd0, done}, 32'd1);
        check("p.fail",  {31'd0, fail}, 32'd0);
        check("p.cnt",   32'(store_count), 32'd1);

        // Wrong data at the checked address -> FAIL
        doReset(32'h64, 32'd7);
        store(32'h20, 32'h64, 32'd5);
        tick();
        MemWrite = 1'b0;
        check("f.fail", {31'd0, fail}, 32'd1);
        check("f.pass", {31'd0, pass}, 32'd0);
        check("f.done", {31'd0, done}, 32'd1);

        // Timeout after exactly MAXC edges
        doReset(32'h64, 32'd7);
        for (int i = 0; i < MAXC - 1; i++) tick();
        check("to.early", {31'd0, fail}, 32'd0);
        tick();
        check("to.fail", {31'd0, fail}, 32'd1);
        check("to.pass", {31'd0, pass}, 32'd0);

        // Overflow: 10 stores into 8 entries, then drain in order
        doReset(32'h1000, 32'd0);
        for (int i = 0; i < 10; i++) begin
            store(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        MemWrite = 1'b0;
        check("ov.drop", 32'(drop_count), 32'd2);
        check("ov.flag", {31'd0, overflow}, 32'd1);
        check("ov.cnt",  32'(store_count), 32'd10);
        checkHead("ov.hold", 0);
        tick();
        checkHead("ov.stable", 0);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkHead("ov.pop", i);
            tick();
        end
        check("ov.empty", {31'd0, trace_valid}, 32'd0);
        check("ov.zpc",   trace_pc, 32'd0);

        // Full FIFO streaming: push and pop every cycle, no drops
        doReset(32'h1000, 32'd0);
        for (int i = 0; i < 8; i++) begin
            store(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        trace_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            checkHead("st.head", k);
            store(32'h100 + 32'(4 * (k + 8)), 32'h200 + 32'(4 * (k + 8)),
                  32'hA0 + 32'(k + 8));
            tick();
        end
        MemWrite = 1'b0;
        check("st.drop", 32'(drop_count), 32'd0);
        check("st.ovf",  {31'd0, overflow}, 32'd0);
        check("st.cnt",  32'(store_count), 32'd28);
        for (int k = 20; k < 28; k++) begin
            checkHead("st.drain", k);
            tick();
        end
        check("st.empty", {31'd0, trace_valid}, 32'd0);

        // Async reset mid-drain
        doReset(32'h300, 32'h55);
        store(32'h100, 32'h300, 32'h55);
        tick();
        for (int i = 1; i < 4; i++) begin
            store(32'h100 + 32'(4 * i), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        MemWrite = 1'b0;
        check("ar.cnt",  32'(store_count), 32'd4);
        check("ar.done", {31'd0, done}, 32'd1);
        trace_ready = 1'b1;
        tick();
        check("ar.valid0", {31'd0, trace_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar.valid", {31'd0, trace_valid}, 32'd0);
        check("ar.cnt0",  32'(store_count), 32'd0);
        check("ar.ovf",   {31'd0, overflow}, 32'd0);
        check("ar.done0", {31'd0, done}, 32'd0);
        check("ar.pc",    trace_pc, 32'd0);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
